// File: rtl/plot_cmd_parser_if.sv
// Byte-stream input and command output bundle of the plotter command parser.
interface plot_cmd_parser_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_x;
    logic [15:0] cmd_y;
    logic        err_chk;
    logic        err_timeout;
    logic        overrun;

    modport slave (
        input  in_valid, in_data, cmd_ready,
        output cmd_valid, cmd_op, cmd_x, cmd_y, err_chk, err_timeout, overrun
    );

    modport master (
        output in_valid, in_data, cmd_ready,
        input  cmd_valid, cmd_op, cmd_x, cmd_y, err_chk, err_timeout, overrun
    );
endinterface

// File: rtl/plot_cmd_parser.sv
// Assembles SYNC/OP/XH/XL/YH/YL[/CHK] frames into a one-deep command holding register.
// Define PLOT_CMD_CHKSUM_EN to add the trailing XOR checksum byte and err_chk reporting.
module plot_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input logic              clk,
    input logic              reset,
    plot_cmd_parser_if.slave bus
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

`ifdef PLOT_CMD_CHKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_OP, S_XH, S_XL, S_YH, S_YL, S_CHK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_OP, S_XH, S_XL, S_YH, S_YL} state_t;
`endif

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] x;
        logic [15:0] y;
    } cmd_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tcnt_q;
    logic [7:0]    op_q, xh_q, xl_q, yh_q;
    cmd_t          cmd_q, fin_cmd;
    logic          cmd_valid_q;
    logic          frame_done, timeout, commit, drop;
    logic          to_q, ovr_q;
`ifdef PLOT_CMD_CHKSUM_EN
    logic [7:0]    yl_q;
    logic          chk_bad, chk_q;
`endif

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        timeout    = 1'b0;
`ifdef PLOT_CMD_CHKSUM_EN
        chk_bad    = 1'b0;
        fin_cmd    = '{op: op_q, x: {xh_q, xl_q}, y: {yh_q, yl_q}};
`else
        // YL is still on the bus in the completing cycle.
        fin_cmd    = '{op: op_q, x: {xh_q, xl_q}, y: {yh_q, bus.in_data}};
`endif
        if (bus.in_valid) begin
            case (state_q)
                S_IDLE: if (bus.in_data == SYNC_BYTE) state_d = S_OP;
                S_OP:   state_d = S_XH;
                S_XH:   state_d = S_XL;
                S_XL:   state_d = S_YH;
                S_YH:   state_d = S_YL;
`ifdef PLOT_CMD_CHKSUM_EN
                S_YL:   state_d = S_CHK;
                S_CHK: begin
                    state_d = S_IDLE;
                    if (bus.in_data != (op_q ^ xh_q ^ xl_q ^ yh_q ^ yl_q))
                        chk_bad = 1'b1;
                    else
                        frame_done = 1'b1;
                end
`else
                S_YL: begin
                    state_d    = S_IDLE;
                    frame_done = 1'b1;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tcnt_q == TMAX) begin
            timeout = 1'b1;
            state_d = S_IDLE;
        end
    end

    // A held command being accepted this cycle frees the slot for the new frame.
    assign commit = frame_done & (~cmd_valid_q | bus.cmd_ready);
    assign drop   = frame_done & cmd_valid_q & ~bus.cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tcnt_q      <= '0;
            op_q        <= '0;
            xh_q        <= '0;
            xl_q        <= '0;
            yh_q        <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            to_q        <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (bus.in_valid || state_q == S_IDLE)
                tcnt_q <= '0;
            else if (tcnt_q != TMAX)
                tcnt_q <= tcnt_q + 1'b1;
            if (bus.in_valid) begin
                case (state_q)
                    S_OP:    op_q <= bus.in_data;
                    S_XH:    xh_q <= bus.in_data;
                    S_XL:    xl_q <= bus.in_data;
                    S_YH:    yh_q <= bus.in_data;
                    default: ;
                endcase
            end
            cmd_valid_q <= commit | (cmd_valid_q & ~bus.cmd_ready);
            if (commit)
                cmd_q <= fin_cmd;
            to_q  <= timeout;
            ovr_q <= drop;
        end
    end

`ifdef PLOT_CMD_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            yl_q  <= '0;
            chk_q <= 1'b0;
        end else begin
            if (bus.in_valid && state_q == S_YL)
                yl_q <= bus.in_data;
            chk_q <= chk_bad;
        end
    end
    assign bus.err_chk = chk_q;
`else
    assign bus.err_chk = 1'b0;
`endif

    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_op      = cmd_q.op;
    assign bus.cmd_x       = cmd_q.x;
    assign bus.cmd_y       = cmd_q.y;
    assign bus.err_timeout = to_q;
    assign bus.overrun     = ovr_q;
endmodule
